// File: rtl/man_align_seq.sv
// Mantissa alignment sequencer: orders two operands by magnitude, then right-shifts the smaller
// mantissa by the exponent difference a few bits per cycle. Optional macro: MAN_ALIGN_FAST_ACCEPT_EN.
module man_align_seq #(
   parameter int MAN_W         = 28,
   parameter int EXP_W         = 8,
   parameter int SHIFT_PER_CYC = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [EXP_W-1:0] i_exp_a,
   input  logic [EXP_W-1:0] i_exp_b,
   input  logic [MAN_W-1:0] i_man_a,
   input  logic [MAN_W-1:0] i_man_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_compare,
   output logic [EXP_W-1:0] o_exp_max,
   output logic [MAN_W-1:0] o_man_max,
   output logic [MAN_W-1:0] o_man_min,
   output logic             o_sticky,
   output logic             o_busy
);

   typedef enum logic [1:0] {IDLE, SWAP, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [EXP_W-1:0] exp_a_q, exp_b_q, exp_max_q, rem_q;
   logic [MAN_W-1:0] man_a_q, man_b_q, man_max_q, man_min_q;
   logic             compare_q, sticky_q;

   // OR of the n least significant bits of v; n never exceeds MAN_W here.
   function automatic logic low_bits_or(input logic [MAN_W-1:0] v, input logic [EXP_W-1:0] n);
      logic [MAN_W-1:0] mask;
      mask = (MAN_W'(1) << n) - MAN_W'(1);
      return |(v & mask);
   endfunction

   logic             compare_d;
   logic [EXP_W-1:0] exp_max_d, exp_min_d, diff_d;
   logic [MAN_W-1:0] man_max_d, man_min_d;
   logic             diff_big_d;

   always_comb begin
      compare_d = (exp_a_q < exp_b_q) || ((exp_a_q == exp_b_q) && (man_a_q < man_b_q));
      if (compare_d) begin
         exp_max_d = exp_b_q;
         exp_min_d = exp_a_q;
         man_max_d = man_b_q;
         man_min_d = man_a_q;
      end else begin
         exp_max_d = exp_a_q;
         exp_min_d = exp_b_q;
         man_max_d = man_a_q;
         man_min_d = man_b_q;
      end
      diff_d     = exp_max_d - exp_min_d;
      diff_big_d = (32'(diff_d) >= 32'(MAN_W));
   end

   logic [EXP_W-1:0] step_d, rem_d;
   logic [MAN_W-1:0] man_min_sh_d;
   logic             sticky_sh_d;

   always_comb begin
      step_d       = (rem_q < EXP_W'(SHIFT_PER_CYC)) ? rem_q : EXP_W'(SHIFT_PER_CYC);
      man_min_sh_d = man_min_q >> step_d;
      sticky_sh_d  = sticky_q | low_bits_or(man_min_q, step_d);
      rem_d        = rem_q - step_d;
   end

`ifdef MAN_ALIGN_FAST_ACCEPT_EN
   assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
`else
   assign o_ready = (state_q == IDLE);
`endif

   logic accept;
   assign accept = i_valid && o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         exp_a_q   <= '0;
         exp_b_q   <= '0;
         man_a_q   <= '0;
         man_b_q   <= '0;
         exp_max_q <= '0;
         rem_q     <= '0;
         man_max_q <= '0;
         man_min_q <= '0;
         compare_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  exp_a_q <= i_exp_a;
                  exp_b_q <= i_exp_b;
                  man_a_q <= i_man_a;
                  man_b_q <= i_man_b;
                  state_q <= SWAP;
               end
            end
            SWAP: begin
               compare_q <= compare_d;
               exp_max_q <= exp_max_d;
               man_max_q <= man_max_d;
               if (diff_big_d) begin
                  // Everything falls off the end: result is zero, sticky catches any set bit.
                  man_min_q <= '0;
                  sticky_q  <= |man_min_d;
                  state_q   <= DONE;
               end else if (diff_d == '0) begin
                  man_min_q <= man_min_d;
                  sticky_q  <= 1'b0;
                  state_q   <= DONE;
               end else begin
                  man_min_q <= man_min_d;
                  sticky_q  <= 1'b0;
                  rem_q     <= diff_d;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               man_min_q <= man_min_sh_d;
               sticky_q  <= sticky_sh_d;
               rem_q     <= rem_d;
               if (rem_d == '0) state_q <= DONE;
            end
            DONE: begin
               // accept can only be true here when the fast-accept path is built in.
               if (i_ready) begin
                  if (accept) begin
                     exp_a_q <= i_exp_a;
                     exp_b_q <= i_exp_b;
                     man_a_q <= i_man_a;
                     man_b_q <= i_man_b;
                     state_q <= SWAP;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_valid   = (state_q == DONE);
   assign o_busy    = (state_q != IDLE);
   assign o_compare = compare_q;
   assign o_exp_max = exp_max_q;
   assign o_man_max = man_max_q;
   assign o_man_min = man_min_q;
   assign o_sticky  = sticky_q;

endmodule

// File: doc/man_align_seq.md
# man_align_seq

Multi-cycle alignment sequencer for the floating-point adder's mantissa path. It accepts two operands (exponent + extended mantissa), decides which is larger, and steers them into max/min order with the same rule as the mantissa swap stage. It then right-shifts the smaller mantissa by the exponent difference, a bounded number of bits per cycle, collecting a sticky bit. Sits between operand unpack and the mantissa add/sub stage, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `MAN_W`, 28, extended mantissa width (hidden + fraction + guard/round bits).
- `EXP_W`, 8, exponent width.
- `SHIFT_PER_CYC`, 4, maximum right-shift bits per SHIFT cycle; power of two, 1..MAN_W.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_valid` in 1: input operands valid.
- `o_ready` out 1: block can accept operands.
- `i_exp_a`, `i_exp_b` in EXP_W: operand exponents.
- `i_man_a`, `i_man_b` in MAN_W: operand mantissas.
- `o_valid` out 1: aligned result valid.
- `i_ready` in 1: downstream accepts result.
- `o_compare` out 1: 1 means a < b, so b was selected as max.
- `o_exp_max` out EXP_W: exponent of larger operand.
- `o_man_max` out MAN_W: larger operand mantissa, unshifted.
- `o_man_min` out MAN_W: smaller operand mantissa, right-shifted by exponent difference.
- `o_sticky` out 1: OR of all bits shifted out of `o_man_min`.
- `o_busy` out 1: state is not IDLE.

## Operation

- FSM states: IDLE, SWAP, SHIFT, DONE. All registers reset to 0 and state resets to IDLE.
- `o_ready` = (state==IDLE). It reads 1 during reset, but nothing is captured while `i_rst_n`=0.
- `o_valid` = (state==DONE). All result outputs are registered.
- IDLE: when `i_valid`&&`o_ready`, capture all four operand inputs and go to SWAP.
- SWAP (one cycle):
  - compare = (exp_a < exp_b) || (exp_a == exp_b && man_a < man_b). Exact equality gives compare=0, so a is max.
  - Load max/min mantissa registers and `o_exp_max`.
  - d = exp_max − exp_min, computed as an unsigned EXP_W-bit value.
  - If d ≥ MAN_W: min ← 0, sticky ← |min, go to DONE.
  - If d == 0: sticky ← 0, go to DONE.
  - Otherwise: rem ← d, sticky ← 0, go to SHIFT.
- SHIFT: each cycle:
  - s = min(rem, SHIFT_PER_CYC).
  - sticky ← sticky | (OR of the low s bits of min).
  - min ← min >> s.
  - rem ← rem − s.
  - Go to DONE when rem − s == 0.
- DONE: hold all outputs stable until `i_ready`=1, then go to IDLE.
- The shifter uses a logical right shift, zero fill. No rounding is done here; the sticky bit is reported separately and is not merged into `o_man_min`.

## Timing

- Accept edge = rising edge where `i_valid`&&`o_ready`.
- Latency, accept edge to `o_valid` high:
  - 2 cycles when d==0 or d≥MAN_W.
  - 2 + ceil(d/SHIFT_PER_CYC) cycles otherwise.
- Throughput without the macro: one operation per latency + 1 cycle, because IDLE is a bubble.
- Backpressure: outputs and `o_valid` stay constant while DONE && !`i_ready`. `o_ready` stays 0, so `i_valid` is ignored.
- Reset mid-operation: asserting `i_rst_n` low immediately forces state to IDLE, `o_valid`=0, `o_busy`=0, and all outputs to 0. The in-flight operation is discarded.
- `i_valid` in any state other than IDLE is ignored. The upstream must hold its operands until `o_ready`.

## Configuration

- `MAN_ALIGN_FAST_ACCEPT_EN` defined:
  - `o_ready` = (state==IDLE) || (state==DONE && `i_ready`).
  - A handshake in DONE with `i_valid` high captures the new operands and goes directly to SWAP, giving zero bubble cycles between operations.
- Not defined: `o_ready` is asserted only in IDLE, as described above.

## Test plan

- Equal exponents: exp_a=exp_b=0x80, man_a=0x0000100, man_b=0x0000200 → `o_compare`=1, `o_man_max`=0x0000200, `o_man_min`=0x0000100, `o_sticky`=0, `o_valid` 2 cycles after accept.
- Multi-cycle shift: exp_a=0x85, exp_b=0x80, man_a=0x8000000, man_b=0x0000121 → `o_compare`=0, `o_exp_max`=0x85, `o_man_min`=0x0000009, `o_sticky`=1, `o_valid` 4 cycles after accept (two SHIFT cycles).
- Overflow shift: exp_a=0x10, exp_b=0x38 (d=40), man_a=0x0000001 → `o_compare`=1, `o_man_min`=0, `o_sticky`=1, latency 2. Repeat with man_a=0 → `o_sticky`=0.
- Backpressure: hold `i_ready`=0 for 10 cycles in DONE → outputs bit-stable, `o_ready`=0, pulsed `i_valid` not captured. Raise `i_ready` → IDLE next cycle.
- Reset mid-SHIFT: d=20, drop `i_rst_n` in the 2nd SHIFT cycle → `o_valid`, `o_busy` and all outputs 0 immediately. After release, a new operation completes with correct results.
- With `MAN_ALIGN_FAST_ACCEPT_EN`: two back-to-back d=0 operations, `i_ready`=1 throughout → second accepted on the first's DONE cycle, `o_valid` high on consecutive operations with one SWAP cycle between them.
